sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Parametrised single-port asynchronous SRAM controller with a req/ready/ack handshake and programmable read wait states and write setup/pulse timing. It drives the board SRAM pins (address, bidirectional data, OE, WE, EN) from registered outputs only. It is the successor to the fixed 18x16 single-cycle RAM1 interface. Instruction fetch and data memory stages of the CPU use it through the handshake, so SRAM timing is no longer tied to the CPU clock.

Parameters:
ADDR_W, 18, address width
DATA_W, 16, data width
RD_WAIT, 2, cycles OE held low before read data is sampled; legal range >=1
WR_SETUP, 1, cycles address/data driven with WE high before the WE pulse; legal range >=0
WR_PULSE, 2, cycles WE held low; legal range >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req  in  1  request valid, sampled only while ready=1
we  in  1  1=write, 0=read; qualified by req
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
ready  out  1  controller idle; can accept req this cycle
ack  out  1  one-cycle pulse: access complete
rdata  out  DATA_W  read result; valid from ack, held until next read ack
RamAddr  out  ADDR_W  SRAM address
RamData  inout  DATA_W  SRAM data bus; tri-state when not writing
RamOE  out  1  SRAM output enable, active-low
RamWE  out  1  SRAM write enable, active-low
RamEN  out  1  SRAM chip enable, active-low

Behaviour:
- Reset (rst=0, async): state IDLE. ready=1, ack=0, rdata=0, RamAddr=0, RamOE=1, RamWE=1, RamEN=1, RamData=Z. Reset mid-access aborts the access: WE/OE deassert immediately, the bus is released, and no ack is issued.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD. A down-counter sized for max(RD_WAIT, WR_SETUP, WR_PULSE) times each state.
- ready = (state==IDLE), combinational from the state register.
- IDLE, req=1 at an edge: latch addr to RamAddr, latch wdata, set RamEN=0.
  - we=0: go to READ, RamOE=0, counter=RD_WAIT-1.
  - we=1: drive latched wdata on RamData. Go to WSETUP with counter=WR_SETUP-1, or straight to WPULSE (RamWE=0, counter=WR_PULSE-1) if WR_SETUP=0.
- READ: stays RD_WAIT cycles. On the last edge: rdata<=RamData, ack<=1, RamOE<=1, RamEN<=1, go to IDLE. Read latency is RD_WAIT+1 edges from the acceptance edge to ack high.
- WSETUP: WE high, address/data stable for WR_SETUP cycles, then WPULSE with RamWE=0.
- WPULSE: WR_PULSE cycles, then RamWE<=1 and go to WHOLD.
- WHOLD: 1 cycle with address/data still driven and WE high (hold time). Then release the bus, RamEN<=1, ack<=1, go to IDLE. Write latency is WR_SETUP+WR_PULSE+2 edges from acceptance to ack.
- ack is high for exactly the first IDLE cycle after completion. A req in that same cycle is accepted (back-to-back, no bubble beyond that cycle).
- req while ready=0 is ignored. The requester holds req/we/addr/wdata until it sees ready=1 at an edge where req is high.
- Bus safety: RamData is driven only in WSETUP/WPULSE/WHOLD. RamOE is never 0 in those states, and RamWE is never 0 while RamOE=0.
- rdata is unchanged by writes. RamAddr holds its last value in IDLE.

Test Plan:
- Reset: assert rst=0 during a WPULSE -> RamWE=1, RamData=Z, ready=1 the same cycle; no ack after release.
- Write then read (defaults): write addr=18'h00001, wdata=16'h0004 -> RamWE low for exactly 2 cycles, data stable from 1 cycle before the WE fall to 1 cycle after the WE rise, ack 5 edges after acceptance. Then read addr 18'h00001 -> RamOE low 2 cycles, ack 3 edges after acceptance, rdata=16'h0004.
- Back-to-back: issue a read of 18'h3FFFF in the ack cycle of a write to 18'h3FFFF (wdata 16'hA5A5) -> accepted with no extra idle cycle, rdata=16'hA5A5.
- Parameter sweep: RD_WAIT=1, WR_SETUP=0, WR_PULSE=1 -> write ack 3 edges after acceptance, read ack 2 edges after acceptance, data correct.
- Busy ignore: toggle req with we=1, addr=5 while ready=0 during a read of addr 3 -> no extra access, exactly one ack, RamAddr stays 3 until done.
- Contention check (assertion across all tests): never (RamOE=0 and RamData driven), never (RamWE=0 and RamOE=0).

Source files
------------

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Brief    : Single-port asynchronous SRAM controller. A req/ready/ack
//            handshake sits in front of programmable read wait states and
//            write setup/pulse timing. Every SRAM pin comes from a register.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] RamAddr,
    inout  wire  [DATA_W-1:0] RamData,
    output logic              RamOE,
    output logic              RamWE,
    output logic              RamEN
);

    // The counter only has to hold the largest reload value,
    // which is max(RD_WAIT, WR_SETUP, WR_PULSE) - 1.
    localparam int c_cnt_max = (RD_WAIT > WR_PULSE)
                             ? ((RD_WAIT  > WR_SETUP) ? RD_WAIT  : WR_SETUP)
                             : ((WR_PULSE > WR_SETUP) ? WR_PULSE : WR_SETUP);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_rd_load    = c_cnt_w'(RD_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(WR_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WSETUP = 3'd2,
        WPULSE = 3'd3,
        WHOLD  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_ack,   w_ack_nxt;
    logic                r_oe_n,  w_oe_n_nxt;
    logic                r_we_n,  w_we_n_nxt;
    logic                r_en_n,  w_en_n_nxt;
    logic                r_drive, w_drive_nxt;

    // State and all pin registers; reset aborts any access and frees the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_en_n  <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_ack   <= w_ack_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_we_n  <= w_we_n_nxt;
            r_en_n  <= w_en_n_nxt;
            r_drive <= w_drive_nxt;
        end
    end

    // Next-state and next-pin values; everything holds unless a state moves it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_ack_nxt   = 1'b0;
        w_oe_n_nxt  = r_oe_n;
        w_we_n_nxt  = r_we_n;
        w_en_n_nxt  = r_en_n;
        w_drive_nxt = r_drive;

        case (r_state)
            IDLE: begin
                if (req) begin
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_en_n_nxt  = 1'b0;
                    if (!we) begin
                        w_state_nxt = READ;
                        w_oe_n_nxt  = 1'b0;
                        w_cnt_nxt   = c_rd_load;
                    end else begin
                        w_drive_nxt = 1'b1;
                        if (WR_SETUP == 0) begin
                            w_state_nxt = WPULSE;
                            w_we_n_nxt  = 1'b0;
                            w_cnt_nxt   = c_pulse_load;
                        end else begin
                            w_state_nxt = WSETUP;
                            w_cnt_nxt   = c_setup_load;
                        end
                    end
                end
            end
            READ: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = RamData;
                    w_ack_nxt   = 1'b1;
                    w_oe_n_nxt  = 1'b1;
                    w_en_n_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            WSETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WPULSE;
                    w_we_n_nxt  = 1'b0;
                    w_cnt_nxt   = c_pulse_load;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            WPULSE: begin
                if (r_cnt == '0) begin
                    w_we_n_nxt  = 1'b1;
                    w_state_nxt = WHOLD;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            WHOLD: begin
                // One cycle of address/data hold after WE rises, then release.
                w_drive_nxt = 1'b0;
                w_en_n_nxt  = 1'b1;
                w_ack_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_oe_n_nxt  = 1'b1;
                w_we_n_nxt  = 1'b1;
                w_en_n_nxt  = 1'b1;
                w_drive_nxt = 1'b0;
            end
        endcase
    end

    assign ready   = (r_state == IDLE);
    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign RamAddr = r_addr;
    assign RamOE   = r_oe_n;
    assign RamWE   = r_we_n;
    assign RamEN   = r_en_n;
    assign RamData = r_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Brief    : Self-checking bench for sram_ctrl. Instance 0 uses the default
//            timing, instance 1 the fastest legal timing. Each instance has
//            its own behavioural asynchronous SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_i   [2];
    logic          we_i    [2];
    logic [AW-1:0] addr_i  [2];
    logic [DW-1:0] wdata_i [2];
    logic          ready_o [2];
    logic          ack_o   [2];
    logic [DW-1:0] rdata_o [2];
    logic [AW-1:0] raddr_o [2];
    logic          oe_o    [2];
    logic          we_o    [2];
    logic          en_o    [2];
    logic          drv     [2];
    logic [DW-1:0] bus_v   [2];
    wire  [DW-1:0] bus_a;
    wire  [DW-1:0] bus_b;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    sram_ctrl u_a (
        .clk(clk), .rst(rst), .req(req_i[0]), .we(we_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .ready(ready_o[0]), .ack(ack_o[0]), .rdata(rdata_o[0]),
        .RamAddr(raddr_o[0]), .RamData(bus_a), .RamOE(oe_o[0]), .RamWE(we_o[0]),
        .RamEN(en_o[0])
    );

    sram_ctrl #(.RD_WAIT(1), .WR_SETUP(0), .WR_PULSE(1)) u_b (
        .clk(clk), .rst(rst), .req(req_i[1]), .we(we_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .ready(ready_o[1]), .ack(ack_o[1]), .rdata(rdata_o[1]),
        .RamAddr(raddr_o[1]), .RamData(bus_b), .RamOE(oe_o[1]), .RamWE(we_o[1]),
        .RamEN(en_o[1])
    );

    // Asynchronous SRAM models: drive while selected with OE low, write on WE rise.
    assign bus_a = (!oe_o[0] && !en_o[0]) ? mem_a[raddr_o[0]] : {DW{1'bz}};
    assign bus_b = (!oe_o[1] && !en_o[1]) ? mem_b[raddr_o[1]] : {DW{1'bz}};
    always @(posedge we_o[0]) if (!en_o[0]) mem_a[raddr_o[0]] = bus_a;
    always @(posedge we_o[1]) if (!en_o[1]) mem_b[raddr_o[1]] = bus_b;

    // Controller-side bus drive enable, observed directly.
    assign drv[0]   = u_a.r_drive;
    assign drv[1]   = u_b.r_drive;
    assign bus_v[0] = bus_a;
    assign bus_v[1] = bus_b;

    int checks   = 0;
    int failures = 0;
    int ack_cnt [2] = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Bus contention watch on both instances, every cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("contention_oe_drive", 32'(!oe_o[d] && drv[d]), 32'd0);
            chk("contention_we_oe",    32'(!we_o[d] && !oe_o[d]), 32'd0);
        end
    end

    // Ack pulses seen per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (ack_o[d]) ack_cnt[d] <= ack_cnt[d] + 1;
    end

    typedef struct {
        int            d;      // instance
        logic          w;      // 1=write
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;     // expected rdata for reads
        int            lat;    // edges from acceptance (inclusive) to ack
        int            low;    // cycles WE low (write) or OE low (read)
        int            setup;  // driven cycles with WE high before the pulse
    } vec_t;

    vec_t vecs [13];

    // One handshake transfer; returns on the negedge of the ack cycle so the
    // next call can issue its request in that same cycle.
    task automatic access(input vec_t v);
        int n, low, setup, hold, bad, waited;
        logic [DW-1:0] rd_before;
        waited = 0;
        while (!ready_o[v.d] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_at_issue", 32'(waited), 32'd0);
        rd_before     = rdata_o[v.d];
        req_i[v.d]    = 1'b1;
        we_i[v.d]     = v.w;
        addr_i[v.d]   = v.a;
        wdata_i[v.d]  = v.wd;
        @(negedge clk);
        req_i[v.d] = 1'b0;
        n = 1; low = 0; setup = 0; hold = 0; bad = 0;
        while (!ack_o[v.d] && n < 40) begin
            if (v.w) begin
                if (!we_o[v.d]) low++;
                else if (low == 0) setup++;
                else hold++;
                if (!drv[v.d] || bus_v[v.d] != v.wd || raddr_o[v.d] != v.a ||
                    !oe_o[v.d] || en_o[v.d]) bad++;
            end else begin
                if (!oe_o[v.d]) low++;
                if (drv[v.d] || raddr_o[v.d] != v.a || en_o[v.d] || !we_o[v.d]) bad++;
            end
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(v.lat));
        chk("strobe_low_cycles", 32'(low), 32'(v.low));
        chk("pins_during_access", 32'(bad), 32'd0);
        if (v.w) begin
            chk("write_setup_cycles", 32'(setup), 32'(v.setup));
            chk("write_hold_cycles", 32'(hold), 32'd1);
            chk("rdata_kept_on_write", 32'(rdata_o[v.d]), 32'(rd_before));
        end else begin
            chk("read_data", 32'(rdata_o[v.d]), 32'(v.rd));
        end
        chk("ack_cycle_bus_released", 32'(drv[v.d]), 32'd0);
        chk("ack_cycle_en_high", 32'(en_o[v.d]), 32'd1);
        chk("ack_cycle_ready", 32'(ready_o[v.d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, a0;
        vec_t rv;
        //            d  w     addr        wdata     rdata     lat low setup
        vecs[0]  = '{0, 1'b1, 18'h00001, 16'h0004, 16'h0000, 5, 2, 1};
        vecs[1]  = '{0, 1'b0, 18'h00001, 16'h0000, 16'h0004, 3, 2, 0};
        vecs[2]  = '{0, 1'b1, 18'h3FFFF, 16'hA5A5, 16'h0000, 5, 2, 1};
        vecs[3]  = '{0, 1'b0, 18'h3FFFF, 16'h0000, 16'hA5A5, 3, 2, 0};
        vecs[4]  = '{0, 1'b1, 18'h00003, 16'h0333, 16'h0000, 5, 2, 1};
        vecs[5]  = '{0, 1'b1, 18'h00005, 16'h0555, 16'h0000, 5, 2, 1};
        vecs[6]  = '{0, 1'b0, 18'h00001, 16'h0000, 16'h0004, 3, 2, 0};
        vecs[7]  = '{1, 1'b1, 18'h00001, 16'h1234, 16'h0000, 3, 1, 0};
        vecs[8]  = '{1, 1'b0, 18'h00001, 16'h0000, 16'h1234, 2, 1, 0};
        vecs[9]  = '{1, 1'b1, 18'h2AAAA, 16'h5555, 16'h0000, 3, 1, 0};
        vecs[10] = '{1, 1'b0, 18'h2AAAA, 16'h0000, 16'h5555, 2, 1, 0};
        vecs[11] = '{1, 1'b1, 18'h3FFFF, 16'hFFFF, 16'h0000, 3, 1, 0};
        vecs[12] = '{1, 1'b0, 18'h00001, 16'h0000, 16'h1234, 2, 1, 0};

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = '0; wdata_i[d] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready",   32'(ready_o[d]), 32'd1);
            chk("rst_ack",     32'(ack_o[d]),   32'd0);
            chk("rst_rdata",   32'(rdata_o[d]), 32'd0);
            chk("rst_ramaddr", 32'(raddr_o[d]), 32'd0);
            chk("rst_oe",      32'(oe_o[d]),    32'd1);
            chk("rst_we",      32'(we_o[d]),    32'd1);
            chk("rst_en",      32'(en_o[d]),    32'd1);
            chk("rst_drive",   32'(drv[d]),     32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Table: every call is issued in the ack cycle of the previous one.
        for (int i = 0; i < 13; i++) access(vecs[i]);

        // Busy ignore: read addr 3 while a write to addr 5 is waved at the port.
        a0 = ack_cnt[0];
        req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 18'h00003;
        @(negedge clk);
        n = 1; bad = 0;
        while (!ack_o[0] && n < 40) begin
            if (raddr_o[0] != 18'h00003) bad++;
            req_i[0] = ~req_i[0]; we_i[0] = 1'b1;
            addr_i[0] = 18'h00005; wdata_i[0] = 16'hDEAD;
            @(negedge clk);
            n++;
        end
        req_i[0] = 1'b0; we_i[0] = 1'b0;
        chk("busy_latency", 32'(n), 32'd3);
        chk("busy_ramaddr_held", 32'(bad), 32'd0);
        chk("busy_read_data", 32'(rdata_o[0]), 32'h0333);
        repeat (4) @(negedge clk);
        chk("busy_single_ack", 32'(ack_cnt[0] - a0), 32'd1);
        chk("busy_ready_after", 32'(ready_o[0]), 32'd1);
        rv = '{0, 1'b0, 18'h00005, 16'h0000, 16'h0555, 3, 2, 0};
        access(rv);

        // Reset in the middle of a write pulse.
        @(negedge clk);
        req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 18'h00007; wdata_i[0] = 16'h7777;
        @(negedge clk);
        req_i[0] = 1'b0;
        n = 0;
        while (we_o[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_in_pulse", 32'(we_o[0]), 32'd0);
        a0 = ack_cnt[0];
        #1 rst = 1'b0;
        #1;
        chk("abort_we_high",  32'(we_o[0]),    32'd1);
        chk("abort_bus_free", 32'(drv[0]),     32'd0);
        chk("abort_ready",    32'(ready_o[0]), 32'd1);
        chk("abort_oe_high",  32'(oe_o[0]),    32'd1);
        chk("abort_en_high",  32'(en_o[0]),    32'd1);
        chk("abort_ack_low",  32'(ack_o[0]),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
        chk("abort_ready_after", 32'(ready_o[0]), 32'd1);
        rv = '{0, 1'b0, 18'h00001, 16'h0000, 16'h0004, 3, 2, 0};
        access(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
